// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
//   - default datapath widths
//   - ALU operation codes carried on ex_alu_op
//   - state encoding for the iterative multiplier
package ex_pkg;

  localparam int EX_PC_WIDTH      = 15;
  localparam int EX_DATA_WIDTH    = 16;
  localparam int EX_REGADDR_WIDTH = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle between the ID/EX register, the forwarding sources,
// the execute stage and the EX/MEM boundary.
//   master : drives ID/EX control/operands and forwarding sources, observes results
//   slave  : the execute stage itself
interface ex_stage_if #(
  parameter int PC_WIDTH      = ex_pkg::EX_PC_WIDTH,
  parameter int DATA_WIDTH    = ex_pkg::EX_DATA_WIDTH,
  parameter int REGADDR_WIDTH = ex_pkg::EX_REGADDR_WIDTH
);

  // ID/EX
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic                     ex_alu_src;
  logic                     ex_branch;
  logic [2:0]               ex_alu_op;
  logic [PC_WIDTH-1:0]      ex_pc;
  logic [DATA_WIDTH-1:0]    ex_reg_data1;
  logic [DATA_WIDTH-1:0]    ex_reg_data2;
  logic [DATA_WIDTH-1:0]    ex_imm_ext;
  logic [REGADDR_WIDTH-1:0] ex_rs;
  logic [REGADDR_WIDTH-1:0] ex_rt;
  logic [REGADDR_WIDTH-1:0] ex_rd;

  // forwarding sources
  logic                     mem_fwd_en;
  logic [REGADDR_WIDTH-1:0] mem_fwd_rd;
  logic [DATA_WIDTH-1:0]    mem_fwd_data;
  logic                     wb_fwd_en;
  logic [REGADDR_WIDTH-1:0] wb_fwd_rd;
  logic [DATA_WIDTH-1:0]    wb_fwd_data;

  // EX/MEM and pipeline control
  logic                     mem_reg_write;
  logic                     mem_mem_read;
  logic                     mem_mem_write;
  logic [DATA_WIDTH-1:0]    mem_alu_result;
  logic [DATA_WIDTH-1:0]    mem_store_data;
  logic [REGADDR_WIDTH-1:0] mem_rd;
  logic                     branch_taken;
  logic [PC_WIDTH-1:0]      branch_target;
  logic                     stall_req;

  modport master (
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_alu_op,
           ex_pc, ex_reg_data1, ex_reg_data2, ex_imm_ext, ex_rs, ex_rt, ex_rd,
           mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data,
    input  mem_reg_write, mem_mem_read, mem_mem_write, mem_alu_result, mem_store_data,
           mem_rd, branch_taken, branch_target, stall_req
  );

  modport slave (
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_alu_op,
           ex_pc, ex_reg_data1, ex_reg_data2, ex_imm_ext, ex_rs, ex_rt, ex_rd,
           mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data,
    output mem_reg_write, mem_mem_read, mem_mem_write, mem_alu_result, mem_store_data,
           mem_rd, branch_taken, branch_target, stall_req
  );

endinterface

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
// Operands are latched on start in IDLE; later changes on a_i/b_i are ignored.
// Ports:
//   clk, reset          clock, synchronous active-high reset (aborts to IDLE)
//   start_i             request a multiply (honoured only in IDLE)
//   a_i, b_i            operands
//   busy_o              high while shifting (BUSY)
//   done_o              high for the single DONE cycle; product_o valid then
//   product_o           low DATA_WIDTH bits of a*b
//
// state | meaning
// IDLE  | waiting for start_i, operands latched on start
// BUSY  | one shift-add per cycle, count 0..DATA_WIDTH-1
// DONE  | product valid for one cycle, then back to IDLE
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = EX_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  localparam int CW = $clog2(DATA_WIDTH);

  mul_state_e            state_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  busy_q;
  logic                  done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // Multiplicand shifts left as the multiplier shifts right, so the
          // LSB of mplier_q always selects the correctly weighted partial product.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (count_q == CW'(DATA_WIDTH - 1)) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID/EX and EX/MEM.
//   - forwarding muxes (MEM over WB over register file, r0 never forwarded)
//   - ALU: ADD SUB AND OR XOR SLL SLT MUL
//   - BEQ-style branch resolve (combinational taken/target)
//   - EX/MEM result registers (mem_* on the bus)
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          ex_stage_if.slave: ID/EX inputs, forwarding sources, mem_* results,
//                branch_taken/branch_target, stall_req
// Build option: define EX_MUL_EN to include the iterative multiplier and its stall
// path. Without it, MUL yields 0 in one cycle and stall_req is tied low.
module ex_stage
  import ex_pkg::*;
#(
  parameter int PC_WIDTH      = EX_PC_WIDTH,
  parameter int DATA_WIDTH    = EX_DATA_WIDTH,
  parameter int REGADDR_WIDTH = EX_REGADDR_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  ex_stage_if.slave bus
);

  logic [DATA_WIDTH-1:0]    fwd_a;
  logic [DATA_WIDTH-1:0]    fwd_b;
  logic [DATA_WIDTH-1:0]    op_b;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic [DATA_WIDTH-1:0]    mul_result;
  logic                     stall;

  logic                     mem_reg_write_d, mem_reg_write_q;
  logic                     mem_mem_read_d,  mem_mem_read_q;
  logic                     mem_mem_write_d, mem_mem_write_q;
  logic [DATA_WIDTH-1:0]    mem_alu_result_d, mem_alu_result_q;
  logic [DATA_WIDTH-1:0]    mem_store_data_d, mem_store_data_q;
  logic [REGADDR_WIDTH-1:0] mem_rd_d, mem_rd_q;

  always_comb begin
    fwd_a = bus.ex_reg_data1;
    if (bus.mem_fwd_en && (bus.mem_fwd_rd == bus.ex_rs) && (bus.ex_rs != '0))
      fwd_a = bus.mem_fwd_data;
    else if (bus.wb_fwd_en && (bus.wb_fwd_rd == bus.ex_rs) && (bus.ex_rs != '0))
      fwd_a = bus.wb_fwd_data;
  end

  always_comb begin
    fwd_b = bus.ex_reg_data2;
    if (bus.mem_fwd_en && (bus.mem_fwd_rd == bus.ex_rt) && (bus.ex_rt != '0))
      fwd_b = bus.mem_fwd_data;
    else if (bus.wb_fwd_en && (bus.wb_fwd_rd == bus.ex_rt) && (bus.ex_rt != '0))
      fwd_b = bus.wb_fwd_data;
  end

  assign op_b = bus.ex_alu_src ? bus.ex_imm_ext : fwd_b;

  always_comb begin
    alu_result = '0;
    case (bus.ex_alu_op)
      ALU_ADD: alu_result = fwd_a + op_b;
      ALU_SUB: alu_result = fwd_a - op_b;
      ALU_AND: alu_result = fwd_a & op_b;
      ALU_OR:  alu_result = fwd_a | op_b;
      ALU_XOR: alu_result = fwd_a ^ op_b;
      ALU_SLL: alu_result = fwd_a << op_b[3:0];
      ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_MUL: alu_result = mul_result;
    endcase
  end

`ifdef EX_MUL_EN
  logic is_mul;
  logic mul_busy;
  logic mul_done;

  assign is_mul = (bus.ex_alu_op == ALU_MUL);

  ex_mul_seq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (is_mul),
    .a_i       (fwd_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_result)
  );

  // The issuing cycle (IDLE with a MUL present) stalls as well; only the DONE
  // cycle lets the MUL advance, so the same instruction is never restarted.
  assign stall = ~reset & (mul_busy | (is_mul & ~mul_done));
`else
  assign mul_result = '0;
  assign stall      = 1'b0;
`endif

  assign bus.branch_taken  = ~reset & bus.ex_branch & (fwd_a == fwd_b);
  assign bus.branch_target = bus.ex_pc + bus.ex_imm_ext[PC_WIDTH-1:0];
  assign bus.stall_req     = stall;

  // A stalled cycle inserts a bubble into EX/MEM.
  always_comb begin
    mem_reg_write_d  = 1'b0;
    mem_mem_read_d   = 1'b0;
    mem_mem_write_d  = 1'b0;
    mem_alu_result_d = '0;
    mem_store_data_d = '0;
    mem_rd_d         = '0;
    if (!stall) begin
      mem_reg_write_d  = bus.ex_reg_write & ~bus.ex_branch;
      mem_mem_read_d   = bus.ex_mem_read;
      mem_mem_write_d  = bus.ex_mem_write;
      mem_alu_result_d = alu_result;
      mem_store_data_d = fwd_b;
      mem_rd_d         = bus.ex_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_alu_result_q <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
    end else begin
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
    end
  end

  assign bus.mem_reg_write  = mem_reg_write_q;
  assign bus.mem_mem_read   = mem_mem_read_q;
  assign bus.mem_mem_write  = mem_mem_write_q;
  assign bus.mem_alu_result = mem_alu_result_q;
  assign bus.mem_store_data = mem_store_data_q;
  assign bus.mem_rd         = mem_rd_q;

endmodule
